// File: rtl/alu_pkg.sv
// Shared types for the 6-bit ALU sequencer slice.
// Widths, opcode and state encodings, operand bundle.
package alu_pkg;

  localparam int DATA_W = 6;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_PASS_A = 4'h0,
    OP_PASS_B = 4'h1,
    OP_INC_A  = 4'h2,
    OP_INC_B  = 4'h3,
    OP_DEC_A  = 4'h4,
    OP_DEC_B  = 4'h5,
    OP_ADD    = 4'h6,
    OP_SUB    = 4'h7,
    OP_AND    = 4'h8,
    OP_OR     = 4'h9,
    OP_XOR    = 4'hA,
    OP_NOT_A  = 4'hB,
    OP_SHL    = 4'hC,
    OP_SHR    = 4'hD,
    OP_MAX    = 4'hE,
    OP_MIN    = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } seq_state_e;

  typedef struct packed {
    alu_op_e           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } opnd_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 6-bit ALU core.
// Carry is the 7th bit of sums/differences (borrow for subtracts).
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  logic [DATA_W:0] aw;
  logic [DATA_W:0] bw;
  logic [DATA_W:0] tmp;

  assign aw = {1'b0, a};
  assign bw = {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    tmp   = '0;
    unique case (op)
      OP_PASS_A: y = a;
      OP_PASS_B: y = b;
      OP_INC_A: begin
        tmp   = aw + 7'd1;
        y     = tmp[DATA_W-1:0];
        carry = tmp[DATA_W];
      end
      OP_INC_B: begin
        tmp   = bw + 7'd1;
        y     = tmp[DATA_W-1:0];
        carry = tmp[DATA_W];
      end
      OP_DEC_A: begin
        tmp   = aw - 7'd1;
        y     = tmp[DATA_W-1:0];
        carry = tmp[DATA_W];
      end
      OP_DEC_B: begin
        tmp   = bw - 7'd1;
        y     = tmp[DATA_W-1:0];
        carry = tmp[DATA_W];
      end
      OP_ADD: begin
        tmp   = aw + bw;
        y     = tmp[DATA_W-1:0];
        carry = tmp[DATA_W];
      end
      OP_SUB: begin
        tmp   = aw - bw;
        y     = tmp[DATA_W-1:0];
        carry = tmp[DATA_W];
      end
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOT_A: y = ~a;
      OP_SHL: begin
        y     = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
      OP_SHR:   y = {1'b0, a[DATA_W-1:1]};
      OP_MAX:   y = (a > b) ? a : b;
      OP_MIN:   y = (a < b) ? a : b;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command/response front end for the 6-bit ALU core.
// One op in flight: accept, execute, hold result until consumed.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_carry,
  output logic [DATA_W-1:0] acc,
  output logic [7:0]        op_count
);

  seq_state_e        state;
  seq_state_e        state_nx;
  opnd_t             opnd;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] core_y;
  logic              core_c;
  logic              accept;

  assign a_sel  = cmd_use_acc ? acc : cmd_a;
  assign accept = (state == S_IDLE) && cmd_valid;

  alu_core u_core (
    .a     (opnd.a),
    .b     (opnd.b),
    .op    (opnd.op),
    .y     (core_y),
    .carry (core_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_RESP;
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd      <= '0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        opnd <= '{op: alu_op_e'(cmd_op),
                  a:  a_sel,
                  b:  cmd_b};
      end
      if (state == S_EXEC) begin
        res_data  <= core_y;
        res_zero  <= (core_y == '0);
        res_carry <= core_c;
        acc       <= core_y;
      end
      // op_count counts consumed responses, not accepted commands
      if (state == S_RESP && res_ready) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side front end for the 6-bit ALU datapath. Accepts one operation per valid/ready handshake, registers operands, runs them through a combinational ALU core, and returns the registered result with zero/carry flags on a valid/ready response channel. It keeps a 6-bit accumulator for chained operations and a completed-operation counter. It sits between a controller or host that issues opcodes and the consumer of results.

## Interface
- No parameters. Data width fixed at 6, opcode width fixed at 4.
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  opcode, 0x0–0xF, encoding below
- cmd_a  in  6  operand A
- cmd_b  in  6  operand B
- cmd_use_acc  in  1  1 = substitute accumulator for operand A
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  6  result
- res_zero  out  1  res_data == 0
- res_carry  out  1  carry/borrow, defined below
- acc  out  6  current accumulator
- op_count  out  8  completed responses, wraps 255→0

## Operation
- Opcodes, all unsigned and modulo 64:
  - 0: A; 1: B; 2: A+1; 3: B+1; 4: A−1; 5: B−1
  - 6: A+B; 7: A−B; 8: A&B; 9: A|B; A: A^B; B: ~A
  - C: A<<1, zero-fill; D: A>>1, zero-fill
  - E: max(A,B); F: min(A,B)
- res_carry:
  - Ops 2, 3, 6: bit 6 of the 7-bit sum.
  - Ops 4, 5, 7: borrow, set when the subtrahend exceeds the minuend.
  - Op C: A[5].
  - All other ops: 0.
- FSM states IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch op, A (or acc when cmd_use_acc=1), and B, then go to EXEC.
  - EXEC: cmd_ready=0. Register core output into res_data, res_zero, and res_carry. Load acc with the result. Go to RESP.
  - RESP: res_valid=1. On res_ready, increment op_count and go to IDLE. Otherwise hold; res_data and flags stay stable.
- The acc value substituted for A is the value at the acceptance edge, i.e. the result of the previous command.
- cmd_valid outside IDLE is ignored. Commands are never queued.

## Timing
- Reset values: cmd_ready=1, res_valid=0, res_data=0, res_zero=0, res_carry=0, acc=0, op_count=0, state=IDLE.
- Command accepted at edge N. Result registered at edge N+1. res_valid is high from edge N+1 until the handshake edge.
- Minimum spacing between command acceptances is 3 cycles (accept, exec, response handshake).
- cmd_ready and res_valid are never high in the same cycle.
- Reset asserted mid-operation (EXEC or RESP):
  - All registers return to reset values asynchronously.
  - The in-flight command is dropped and op_count is not incremented.
- op_count wraps to 0 after 255 without any flag.
- res_ready while not in RESP is ignored.

## Structure
- Shared package `alu_pkg`:
  - width constants (DATA_W=6, OP_W=4)
  - opcode enum `alu_op_e` (OP_PASS_A … OP_MIN)
  - state enum `seq_state_e`
- One sub-module `alu_core`: purely combinational. Inputs a, b, op. Outputs y[5:0] and carry. It is instanced once, fed from the operand registers.
- The sequencer holds the FSM, operand registers, result registers, acc, and op_count.

## Test plan
- op 6, A=63, B=1 → res_data=0, res_zero=1, res_carry=1, op_count=1.
- op 7, A=2, B=5 → res_data=61, res_carry=1. op 7, A=5, B=2 → 3, res_carry=0.
- Chain: op 0 with A=10, then op 2 with use_acc=1 and A=0 → results 10 then 11, acc=11.
- Shifts and compares, A=0x21:
  - op C → 0x02, carry=1
  - op D → 0x10
  - op E with A=5, B=9 → 9
  - op F with A=5, B=9 → 5
- Backpressure: res_ready held low for 5 cycles in RESP while cmd_valid toggles:
  - res_data stable, cmd_ready=0, no new command accepted
  - after res_ready pulse, op_count increments by exactly 1
- Reset pulse during EXEC → all outputs at reset values immediately; after release cmd_ready=1, op_count=0, acc=0.
